// File: rtl/sprite_blit.sv
// Sprite blitter: walks a 32x32 sprite through a fixed-latency ROM and writes the
// non-transparent, on-screen pixels into the framebuffer.
//   state | meaning
//   IDLE  | ready for a request
//   START | one-cycle kick of the coordinate counter
//   RUN   | coordinates arrive, ROM reads issued
//   DRAIN | ROM pipeline empties, done on the last cycle
module sprite_blit #(
    parameter int ROM_LAT = 2,
    parameter int SCR_W   = 640,
    parameter int SCR_H   = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_id,
    input  logic [10:0] req_x,
    input  logic [10:0] req_y,
    output logic        nxt_sprt,
    input  logic        fb_en,
    input  logic        nxt,
    input  logic [4:0]  sprite_x,
    input  logic [4:0]  sprite_y,
    output logic [13:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [3:0]  fb_data,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;

    localparam logic signed [11:0] SCR_W_S = 12'(SCR_W);
    localparam logic signed [11:0] SCR_H_S = 12'(SCR_H);

    state_t      state, state_nxt;
    logic [3:0]  id_q;
    logic [10:0] x_q, y_q;
    logic [2:0]  drain_cnt;
    logic        push;

    logic                  pv [ROM_LAT];
    logic [4:0]            px [ROM_LAT];
    logic [4:0]            py [ROM_LAT];
    logic signed [11:0]    sx, sy;
    logic                  on_scr;
    logic                  wr;
    logic [18:0]           addr_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            id_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                id_q <= req_id;
                x_q  <= req_x;
                y_q  <= req_y;
            end
            // Down-counter: loaded while running so DRAIN lasts ROM_LAT+1 cycles.
            if (state == RUN)
                drain_cnt <= 3'(ROM_LAT);
            else if (state == DRAIN && drain_cnt != 3'd0)
                drain_cnt <= drain_cnt - 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        nxt_sprt  = 1'b0;
        done      = 1'b0;
        push      = 1'b0;
        rom_addr  = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = START;
            end
            START: begin
                nxt_sprt  = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (fb_en) begin
                    push     = 1'b1;
                    rom_addr = {id_q, sprite_y, sprite_x};
                    if (nxt) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == 3'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Coordinate pipeline matched to the ROM latency; bubbles travel as invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                pv[i] <= 1'b0;
                px[i] <= '0;
                py[i] <= '0;
            end
        end else begin
            pv[0] <= push;
            px[0] <= sprite_x;
            py[0] <= sprite_y;
            for (int i = 1; i < ROM_LAT; i++) begin
                pv[i] <= pv[i-1];
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
        end
    end

    assign sx = $signed({x_q[10], x_q}) + $signed({7'b0, px[ROM_LAT-1]});
    assign sy = $signed({y_q[10], y_q}) + $signed({7'b0, py[ROM_LAT-1]});

    assign on_scr = (sx >= 0) && (sx < SCR_W_S) && (sy >= 0) && (sy < SCR_H_S);
    assign wr     = pv[ROM_LAT-1] && on_scr && (rom_data != 4'd0);
    assign addr_c = 19'(sy[10:0]) * 19'(SCR_W) + 19'(sx[10:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            fb_we <= wr;
            if (wr) begin
                fb_addr <= addr_c;
                fb_data <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blit.sv
// Bench for sprite_blit: ROM and coordinate-counter models drive the block, and a
// queue of expected framebuffer writes is checked cycle by cycle.
module tb_sprite_blit;
    localparam int ROM_LAT = 2;
    localparam int SCR_W   = 640;
    localparam int SCR_H   = 480;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [3:0]  req_id;
    logic [10:0] req_x, req_y;
    logic        nxt_sprt, fb_en, nxt;
    logic [4:0]  sprite_x, sprite_y;
    logic [13:0] rom_addr;
    logic [3:0]  rom_data;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [3:0]  fb_data;
    logic        busy, done;

    sprite_blit #(.ROM_LAT(ROM_LAT), .SCR_W(SCR_W), .SCR_H(SCR_H)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_x(req_x), .req_y(req_y), .nxt_sprt(nxt_sprt),
        .fb_en(fb_en), .nxt(nxt), .sprite_x(sprite_x), .sprite_y(sprite_y),
        .rom_addr(rom_addr), .rom_data(rom_data), .fb_we(fb_we),
        .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [18:0] addr; logic [3:0] data; } wr_t;
    wr_t sb[$];

    int   cyc = 0;
    int   n_chk = 0, n_pass = 0, n_fail = 0;
    int   wr_cnt, done_cnt, sprt_cnt, rom_min, rom_max;
    int   done_due = -1;
    int   cur_id, cur_x, cur_y, rom_mode = 0;
    bit   bubbles = 0, chk_on = 0;
    logic [18:0] first_addr, last_addr;
    logic [13:0] hist [ROM_LAT];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] rom_val(int mode, logic [13:0] a);
        case (mode)
            0:       return 4'd5;
            1:       return (a[5] ^ a[0]) ? 4'd7 : 4'd0;
            default: return a[3:0];
        endcase
    endfunction

    // ROM model: data for an address appears ROM_LAT cycles later
    assign rom_data = rom_val(rom_mode, hist[ROM_LAT-1]);

    always @(posedge clk) begin
        hist[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) hist[i] <= hist[i-1];
        cyc <= cyc + 1;
        if (rst) begin
            sb.delete();
            done_due = -1;
        end
    end

    task automatic present(int k);
        logic [13:0] ea;
        int px, py;
        ea = {4'(cur_id), 5'(k / 32), 5'(k % 32)};
        #1;
        check("rom_addr", 32'(rom_addr), 32'(ea));
        if (int'(rom_addr) < rom_min) rom_min = int'(rom_addr);
        if (int'(rom_addr) > rom_max) rom_max = int'(rom_addr);
        px = cur_x + k % 32;
        py = cur_y + k / 32;
        if (px >= 0 && px < SCR_W && py >= 0 && py < SCR_H && rom_val(rom_mode, ea) != 4'd0)
            sb.push_back('{cyc + ROM_LAT + 1, 19'(py * SCR_W + px), rom_val(rom_mode, ea)});
        if (k == 1023) done_due = cyc + ROM_LAT + 1;
    endtask

    // Coordinate counter model; with bubbles it also drives junk outside RUN.
    initial begin
        bit active = 0;
        int k = 0;
        fb_en = 0; nxt = 0; sprite_x = 0; sprite_y = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0; fb_en = 0; nxt = 0;
            end else if (active) begin
                if (bubbles && $urandom_range(0, 3) == 0) begin
                    fb_en = 0; nxt = 1'($urandom);
                    sprite_x = 5'($urandom); sprite_y = 5'($urandom);
                end else begin
                    sprite_x = 5'(k % 32); sprite_y = 5'(k / 32);
                    fb_en = 1; nxt = (k == 1023);
                    present(k);
                    k++;
                    if (k == 1024) active = 0;
                end
            end else begin
                if (nxt_sprt === 1'b1) begin
                    active = 1; k = 0;
                end
                fb_en = bubbles ? 1'($urandom) : 1'b0;
                nxt   = bubbles ? 1'($urandom) : 1'b0;
                sprite_x = 5'($urandom); sprite_y = 5'($urandom);
            end
        end
    end

    // Output monitor: every cycle fb_we and done must match the scoreboard.
    initial begin
        wr_t e;
        logic exp_we;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                exp_we = (sb.size() > 0) && (sb[0].due == cyc);
                check("fb_we", 32'(fb_we), 32'(exp_we));
                if (exp_we) begin
                    e = sb.pop_front();
                    if (fb_we === 1'b1) begin
                        check("fb_addr", 32'(fb_addr), 32'(e.addr));
                        check("fb_data", 32'(fb_data), 32'(e.data));
                    end
                end
                if (fb_we === 1'b1) begin
                    wr_cnt++;
                    if (wr_cnt == 1) first_addr = fb_addr;
                    last_addr = fb_addr;
                end
                check("done", 32'(done), 32'(done_due == cyc));
                if (done === 1'b1) done_cnt++;
                if (nxt_sprt === 1'b1) sprt_cnt++;
            end
        end
    end

    task automatic clear_stats();
        wr_cnt = 0; done_cnt = 0; sprt_cnt = 0; rom_min = 99999; rom_max = -1;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1;
        end
        if (!seen) check("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic run_sprite(int id, int x, int y, int mode, bit bub);
        clear_stats();
        cur_id = id; cur_x = x; cur_y = y; rom_mode = mode; bubbles = bub;
        req_id = 4'(id); req_x = 11'(x); req_y = 11'(y); req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        wait_done();
        repeat (ROM_LAT + 4) @(negedge clk);
        bubbles = 0;
    endtask

    initial begin
        rst = 1; req_valid = 0; req_id = 0; req_x = 0; req_y = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fb_we", 32'(fb_we), 32'(0));
        check("rst_nxt_sprt", 32'(nxt_sprt), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_rom_addr", 32'(rom_addr), 32'(0));
        check("rst_fb_addr", 32'(fb_addr), 32'(0));
        check("rst_fb_data", 32'(fb_data), 32'(0));
        rst = 0;
        chk_on = 1;

        run_sprite(3, 100, 50, 0, 0);
        check("t1_writes", 32'(wr_cnt), 32'(1024));
        check("t1_first", 32'(first_addr), 32'(32100));
        check("t1_last", 32'(last_addr), 32'(51971));
        check("t1_rom_min", 32'(rom_min), 32'(3072));
        check("t1_rom_max", 32'(rom_max), 32'(4095));
        check("t1_done_cnt", 32'(done_cnt), 32'(1));
        check("t1_sprt_cnt", 32'(sprt_cnt), 32'(1));

        run_sprite(0, 0, 0, 1, 0);
        check("t2_writes", 32'(wr_cnt), 32'(512));
        check("t2_done_cnt", 32'(done_cnt), 32'(1));

        run_sprite(6, -16, -16, 0, 0);
        check("t3a_writes", 32'(wr_cnt), 32'(256));
        check("t3a_first", 32'(first_addr), 32'(0));

        run_sprite(7, 630, 470, 0, 0);
        check("t3b_writes", 32'(wr_cnt), 32'(100));
        check("t3b_last", 32'(last_addr), 32'(307199));

        // request held through a whole sprite, then accepted right after done
        clear_stats();
        cur_id = 1; cur_x = 10; cur_y = 10; rom_mode = 0;
        req_id = 4'd1; req_x = 11'd10; req_y = 11'd10; req_valid = 1;
        @(negedge clk);
        req_id = 4'd2; req_x = 11'd300; req_y = 11'd200;
        repeat (20) @(negedge clk);
        check("t4_ready_run", 32'(req_ready), 32'(0));
        check("t4_busy_run", 32'(busy), 32'(1));
        wait_done();
        cur_id = 2; cur_x = 300; cur_y = 200;
        @(negedge clk);
        check("t4_ready_after", 32'(req_ready), 32'(1));
        @(negedge clk);
        check("t4_nxt_sprt", 32'(nxt_sprt), 32'(1));
        req_valid = 0;
        wait_done();
        repeat (ROM_LAT + 4) @(negedge clk);
        check("t4_writes", 32'(wr_cnt), 32'(2048));
        check("t4_sprt_cnt", 32'(sprt_cnt), 32'(2));
        check("t4_done_cnt", 32'(done_cnt), 32'(2));

        // reset in the middle of RUN
        clear_stats();
        cur_id = 4; cur_x = 50; cur_y = 60; rom_mode = 0;
        req_id = 4'd4; req_x = 11'd50; req_y = 11'd60; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        repeat (100) @(negedge clk);
        check("t5_busy_before", 32'(busy), 32'(1));
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("t5_fb_we", 32'(fb_we), 32'(0));
        check("t5_busy", 32'(busy), 32'(0));
        check("t5_req_ready", 32'(req_ready), 32'(1));
        clear_stats();
        repeat (40) @(negedge clk);
        check("t5_no_writes", 32'(wr_cnt), 32'(0));
        check("t5_no_done", 32'(done_cnt), 32'(0));

        run_sprite(5, 200, 100, 2, 1);
        check("t6_writes", 32'(wr_cnt), 32'(960));
        check("t6_done_cnt", 32'(done_cnt), 32'(1));
        check("t6_sprt_cnt", 32'(sprt_cnt), 32'(1));
        check("t6_queue_empty", 32'(sb.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sprite_blit.md
SPRITE_BLIT -- requirements
Module: sprite_blit

Interface
REQ-001 Parameter ROM_LAT, default 2, sprite ROM read latency in cycles (1..4).
REQ-002 Parameter SCR_W, default 640, framebuffer width in pixels.
REQ-003 Parameter SCR_H, default 480, framebuffer height in pixels.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  sprite draw request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_id  input  4  sprite index, 0..15.
REQ-009 req_x  input  11  signed screen X of sprite top-left.
REQ-010 req_y  input  11  signed screen Y of sprite top-left.
REQ-011 nxt_sprt  output  1  one-cycle start pulse to the 32x32 coordinate counter.
REQ-012 fb_en  input  1  counter coordinate valid.
REQ-013 nxt  input  1  counter at final coordinate (31,31).
REQ-014 sprite_x  input  5  counter X offset.
REQ-015 sprite_y  input  5  counter Y offset.
REQ-016 rom_addr  output  14  sprite ROM address = {id, sprite_y, sprite_x}.
REQ-017 rom_data  input  4  palette index, valid ROM_LAT cycles after rom_addr.
REQ-018 fb_we  output  1  framebuffer write strobe.
REQ-019 fb_addr  output  19  framebuffer address = sy*SCR_W + sx.
REQ-020 fb_data  output  4  pixel palette index.
REQ-021 busy  output  1  high in any state except IDLE.
REQ-022 done  output  1  one-cycle pulse when a sprite has fully drained.

Function
REQ-023 The FSM SHALL have states IDLE, START, RUN and DRAIN.
REQ-024 IDLE: req_ready=1; on req_valid, latch id/x/y and go to START next cycle.
REQ-025 START: nxt_sprt=1 for exactly one cycle, then go to RUN.
REQ-026 RUN: in each cycle with fb_en=1, issue rom_addr combinationally and push {valid, sprite_x, sprite_y} into a ROM_LAT-deep pipeline.
REQ-027 RUN: a cycle with fb_en=0 SHALL push an invalid bubble, with no write resulting from it.
REQ-028 RUN: when fb_en=1 and nxt=1, that coordinate is pushed and the FSM goes to DRAIN.
REQ-029 DRAIN: hold for ROM_LAT+1 cycles, pulse done on the last cycle, then return to IDLE.
REQ-030 Write stage: sx = req_x + sprite_x and sy = req_y + sprite_y, computed as 12-bit signed values.
REQ-031 The write condition SHALL be: pipeline valid, 0<=sx<SCR_W, 0<=sy<SCR_H and rom_data!=0 (index 0 is transparent).
REQ-032 fb_we/fb_addr/fb_data SHALL be registered; the write for a coordinate presented in cycle t appears in cycle t+ROM_LAT+1.
REQ-033 fb_addr SHALL be computed at full width with no truncation for any on-screen pixel.
REQ-034 req_valid outside IDLE SHALL be ignored; req_ready=0.
REQ-035 fb_en or nxt in IDLE/START/DRAIN SHALL be ignored; nothing is pushed.
REQ-036 Latched id/x/y SHALL remain stable from acceptance until done.
REQ-037 The block SHALL produce at most one fb_we per cycle and exactly one done per accepted request.

Reset
REQ-038 On rst, the block SHALL go to IDLE and clear all pipeline valids.
REQ-039 On rst, outputs SHALL be: fb_we=0, nxt_sprt=0, done=0, busy=0, req_ready=1, and rom_addr/fb_addr/fb_data=0.
REQ-040 rst mid-operation SHALL abort the sprite: no further fb_we and no done pulse.

Verification
REQ-041 id=3 at (100,50), ROM all 5: 1024 writes; first fb_addr=32100, last=51971; fb_data=5; rom_addr range 3072..4095; one done pulse.
REQ-042 Checkerboard ROM (0/7) at (0,0): exactly 512 writes, none with fb_data=0.
REQ-043 Sprite at (-16,-16): 256 writes, first fb_addr=0. Sprite at (630,470): 100 writes, last fb_addr=307199.
REQ-044 req_valid held during RUN: req_ready=0 and the request is not accepted. It is accepted the cycle after done, and nxt_sprt pulses once per request.
REQ-045 rst asserted in RUN: next cycle fb_we=0, busy=0, req_ready=1, and no done follows.
REQ-046 Counter model inserting fb_en bubbles: write count is unchanged, no writes occur for bubble cycles, and write latency equals ROM_LAT+1.
